// File: rtl/sprite_blit.sv
// sprite_blit: XOR sprite blitter with private 1bpp pixel store, clip/wrap edges and priority scan-out port
module sprite_blit #(
  parameter int X_BITS     = 6,
  parameter int Y_BITS     = 5,
  parameter int ADDR_WIDTH = 12,
  parameter int MEM_LAT    = 1,
  parameter int WRAP       = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [ADDR_WIDTH-1:0]    I,
  input  logic [7:0]               x,
  input  logic [7:0]               y,
  input  logic [3:0]               n,
  output logic                     busy,
  output logic                     done,
  output logic                     col,
  output logic [ADDR_WIDTH-1:0]    mem_raddr,
  output logic                     mem_re,
  input  logic [7:0]               mem_d,
  input  logic                     scan_en,
  input  logic [X_BITS+Y_BITS-1:0] scan_addr,
  output logic                     scan_q
);
  localparam int A  = X_BITS + Y_BITS;
  localparam int LW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PIX, WR, CLR, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] i_q, i_d, mem_raddr_q, mem_raddr_d;
  logic [X_BITS-1:0] x0_q, x0_d;
  logic [Y_BITS-1:0] y0_q, y0_d;
  logic [3:0] n_q, n_d, r_q, r_d;
  logic [2:0] b_q, b_d;
  logic [7:0] sh_q, sh_d;
  logic [LW-1:0] wc_q, wc_d;
  logic [A-1:0] k_q, k_d, paddr, waddr;
  logic h_q, h_d, d16_q, d16_d, col_q, col_d, mem_re_q, scan_q_q, rd_q;
  logic [X_BITS:0] xs;
  logic [Y_BITS:0] ys;
  logic clip, pix_on, last_row, re, we, wdat, adv;
  logic store [2**A];
  logic unused_ok;
  assign unused_ok = ^{x[7:X_BITS], y[7:Y_BITS]};
  // Column/row carry one extra bit so a carry out flags a clipped pixel
  assign xs = {1'b0, x0_q} + (X_BITS+1)'({h_q, b_q});
  assign ys = {1'b0, y0_q} + (Y_BITS+1)'(r_q);
  assign clip = (WRAP == 0) && (xs[X_BITS] || ys[Y_BITS]);
  assign pix_on = sh_q[~b_q] && !clip;
  assign last_row = d16_q ? &r_q : r_q == n_q - 4'd1;
  assign paddr = {ys[Y_BITS-1:0], xs[X_BITS-1:0]};
  assign re = state_q == PIX && pix_on && !scan_en;
  assign we = (state_q == WR || state_q == CLR) && !scan_en;
  assign waddr = state_q == CLR ? k_q : paddr;
  assign wdat = state_q == WR && !rd_q;
  assign adv = (state_q == PIX && !pix_on) || (state_q == WR && !scan_en);
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign col = col_q;
  assign mem_re = mem_re_q;
  assign mem_raddr = mem_raddr_q;
  assign scan_q = scan_q_q;
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    x0_d = x0_q;
    y0_d = y0_q;
    n_d = n_q;
    r_d = r_q;
    h_d = h_q;
    b_d = b_q;
    d16_d = d16_q;
    sh_d = sh_q;
    wc_d = wc_q;
    k_d = k_q;
    col_d = col_q;
    case (state_q)
      IDLE: if (start) begin
        i_d = I;
        x0_d = x[X_BITS-1:0];
        y0_d = y[Y_BITS-1:0];
        n_d = n;
        d16_d = op == 2'd2;
        r_d = '0;
        h_d = 1'b0;
        b_d = '0;
        k_d = '0;
        col_d = op == 2'd3 ? col_q : 1'b0;
        state_d = op == 2'd1 ? CLR : (op == 2'd3 || (op == 2'd0 && n == 4'd0)) ? DONE : FETCH;
      end
      FETCH: begin
        wc_d = LW'(MEM_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        wc_d = wc_q - LW'(1);
        sh_d = wc_q == '0 ? mem_d : sh_q;
        state_d = wc_q == '0 ? PIX : WAIT;
      end
      PIX: state_d = pix_on && !scan_en ? WR : PIX;
      WR: col_d = scan_en ? col_q : col_q | rd_q;
      CLR: if (!scan_en) begin
        k_d = k_q + 1'b1;
        state_d = &k_q ? DONE : CLR;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // End of a byte moves to the right half of a draw16 row or to the next row
    if (adv) begin
      b_d = b_q + 3'd1;
      state_d = PIX;
      if (&b_q) begin
        h_d = d16_q && !h_q;
        r_d = h_d ? r_q : r_q + 4'd1;
        state_d = (!h_d && last_row) ? DONE : FETCH;
      end
    end
  end
  assign mem_raddr_d = state_d == FETCH ? i_d + ADDR_WIDTH'(d16_d ? {r_d, h_d} : {1'b0, r_d}) : mem_raddr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q <= '0;
      x0_q <= '0;
      y0_q <= '0;
      n_q <= '0;
      r_q <= '0;
      h_q <= 1'b0;
      b_q <= '0;
      d16_q <= 1'b0;
      sh_q <= '0;
      wc_q <= '0;
      k_q <= '0;
      col_q <= 1'b0;
      mem_re_q <= 1'b0;
      mem_raddr_q <= '0;
      scan_q_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      x0_q <= x0_d;
      y0_q <= y0_d;
      n_q <= n_d;
      r_q <= r_d;
      h_q <= h_d;
      b_q <= b_d;
      d16_q <= d16_d;
      sh_q <= sh_d;
      wc_q <= wc_d;
      k_q <= k_d;
      col_q <= col_d;
      mem_re_q <= state_d == FETCH;
      mem_raddr_q <= mem_raddr_d;
      if (scan_en) scan_q_q <= store[scan_addr];
    end
  end
  always_ff @(posedge clk) begin
    if (we) store[waddr] <= wdat;
    if (re) rd_q <= store[paddr];
  end
endmodule

// File: tb/tb_sprite_blit.sv
// tb_sprite_blit: directed checks of a 64x32 clip blitter and a 128x64 wrap blitter with MEM_LAT=2
module tb_sprite_blit;
  logic clk = 0, rst = 1;
  logic start1 = 0, start2 = 0;
  logic [1:0] op = 0;
  logic [11:0] I = 0;
  logic [7:0] x = 0, y = 0;
  logic [3:0] n = 0;
  logic busy1, done1, col1, re1, busy2, done2, col2, re2;
  logic [11:0] ra1, ra2;
  logic [7:0] md1 = 0, md2 = 0, p2a = 0;
  logic sen1 = 0, sen2 = 0, sq1, sq2;
  logic [10:0] sa1 = 0;
  logic [12:0] sa2 = 0;
  logic [7:0] pm [4096];
  logic [11:0] flog [256];
  logic [7:0] fcnt = 0;
  int total = 0, bad = 0;
  int c, cnt, ones;
  logic v;

  always #5 clk = ~clk;

  sprite_blit dut1 (
    .clk(clk), .rst(rst), .start(start1), .op(op), .I(I), .x(x), .y(y), .n(n),
    .busy(busy1), .done(done1), .col(col1), .mem_raddr(ra1), .mem_re(re1), .mem_d(md1),
    .scan_en(sen1), .scan_addr(sa1), .scan_q(sq1)
  );

  sprite_blit #(.X_BITS(7), .Y_BITS(6), .MEM_LAT(2), .WRAP(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .op(op), .I(I), .x(x), .y(y), .n(n),
    .busy(busy2), .done(done2), .col(col2), .mem_raddr(ra2), .mem_re(re2), .mem_d(md2),
    .scan_en(sen2), .scan_addr(sa2), .scan_q(sq2)
  );

  always_ff @(posedge clk) md1 <= re1 ? pm[ra1] : 8'h00;
  always_ff @(posedge clk) begin
    p2a <= re2 ? pm[ra2] : 8'h00;
    md2 <= p2a;
    if (re2) begin
      flog[fcnt] <= ra2;
      fcnt <= fcnt + 8'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic go(input int w, input logic [1:0] o, input logic [11:0] ia,
                    input logic [7:0] xx, input logic [7:0] yy, input logic [3:0] nn);
    @(negedge clk);
    op = o; I = ia; x = xx; y = yy; n = nn;
    if (w == 1) start1 = 1; else start2 = 1;
    @(negedge clk);
    start1 = 0; start2 = 0;
  endtask

  task automatic wdone(input int w, input int c0, output int cyc);
    cyc = c0;
    while (!(w == 1 ? done1 : done2) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pix(input int w, input int px, input int py, output logic pv);
    @(negedge clk);
    if (w == 1) begin sen1 = 1; sa1 = 11'(py * 64 + px); end
    else begin sen2 = 1; sa2 = 13'(py * 128 + px); end
    @(negedge clk);
    pv = w == 1 ? sq1 : sq2;
    sen1 = 0; sen2 = 0;
  endtask

  task automatic count(input int w, output int cc);
    int nn;
    nn = w == 1 ? 2048 : 8192;
    cc = 0;
    @(negedge clk);
    if (w == 1) begin sen1 = 1; sa1 = 0; end else begin sen2 = 1; sa2 = 0; end
    for (int a = 1; a <= nn; a++) begin
      @(negedge clk);
      cc += int'(w == 1 ? sq1 : sq2);
      sa1 = 11'(a); sa2 = 13'(a);
    end
    sen1 = 0; sen2 = 0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) pm[i] = 8'h00;
    pm[12'h200] = 8'h80;
    pm[12'h210] = 8'hFF;
    pm[12'h211] = 8'hFF;
    for (int i = 0; i < 32; i++) pm[12'h300 + i] = 8'hFF;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_col", col1, 0);
    chk("rst_mem_re", re1, 0);
    chk("rst_raddr", ra1, 0);
    chk("rst_scan_q", sq1, 0);
    rst = 0;
    go(1, 2'd1, 12'h0, 8'h0, 8'h0, 4'd0);
    wdone(1, 1, c);
    chk("clr1_cycles", c, 2049);
    go(2, 2'd1, 12'h0, 8'h0, 8'h0, 4'd0);
    wdone(2, 1, c);
    chk("clr2_cycles", c, 8193);
    // draw8 single pixel at origin
    go(1, 2'd0, 12'h200, 8'd0, 8'd0, 4'd1);
    chk("t1_busy", busy1, 1);
    chk("t1_mem_re", re1, 1);
    chk("t1_raddr", ra1, 12'h200);
    @(negedge clk);
    chk("t1_mem_re_off", re1, 0);
    wdone(1, 2, c);
    chk("t1_cycles", c, 12);
    chk("t1_col", col1, 0);
    @(negedge clk);
    chk("t1_busy_after", busy1, 0);
    chk("t1_done_after", done1, 0);
    pix(1, 0, 0, v);
    chk("t1_px00", v, 1);
    pix(1, 1, 0, v);
    chk("t1_px10", v, 0);
    go(1, 2'd0, 12'h200, 8'd0, 8'd0, 4'd1);
    wdone(1, 1, c);
    chk("t2_cycles", c, 12);
    chk("t2_col", col1, 1);
    pix(1, 0, 0, v);
    chk("t2_px00", v, 0);
    go(1, 2'd3, 12'h200, 8'd0, 8'd0, 4'd1);
    wdone(1, 1, c);
    chk("op3_cycles", c, 1);
    chk("op3_col_kept", col1, 1);
    go(1, 2'd0, 12'h200, 8'd0, 8'd0, 4'd0);
    wdone(1, 1, c);
    chk("n0_cycles", c, 1);
    chk("n0_col_clr", col1, 0);
    // clipped draw at bottom-right, with a start pulse while busy and one in DONE
    go(1, 2'd0, 12'h210, 8'hFE, 8'h3F, 4'd2);
    repeat (3) @(negedge clk);
    op = 2'd1; start1 = 1;
    @(negedge clk);
    start1 = 0;
    wdone(1, 5, c);
    chk("t3_cycles", c, 23);
    chk("t3_col", col1, 0);
    start1 = 1;
    @(negedge clk);
    start1 = 0;
    chk("start_in_done_ign", busy1, 0);
    @(negedge clk);
    chk("start_in_done_ign2", busy1, 0);
    pix(1, 62, 31, v);
    chk("t3_px62_31", v, 1);
    pix(1, 63, 31, v);
    chk("t3_px63_31", v, 1);
    pix(1, 0, 31, v);
    chk("t3_px0_31", v, 0);
    pix(1, 62, 0, v);
    chk("t3_px62_0", v, 0);
    count(1, cnt);
    chk("t3_count", cnt, 2);
    // clear with scan_en toggling; scan watches pixel (62,31) at address 2046
    sa1 = 11'd2046;
    go(1, 2'd1, 12'h0, 8'd0, 8'd0, 4'd0);
    c = 1; ones = 0; sen1 = 1;
    while (!done1 && c < 6000) begin
      @(negedge clk);
      c++;
      if (c[0] == 1'b0) ones += int'(sq1);
      sen1 = c[0];
    end
    sen1 = 0;
    chk("clrs_cycles", c, 4097);
    chk("clrs_stale_reads", ones, 2047);
    count(1, cnt);
    chk("clrs_count", cnt, 0);
    // wrap draw on the 128x64 instance, drawn twice to erase it again
    go(2, 2'd0, 12'h210, 8'hFE, 8'h3F, 4'd2);
    wdone(2, 1, c);
    chk("w1_cycles", c, 39);
    chk("w1_col", col2, 0);
    pix(2, 126, 63, v);
    chk("w1_px126_63", v, 1);
    pix(2, 5, 63, v);
    chk("w1_px5_63", v, 1);
    pix(2, 6, 63, v);
    chk("w1_px6_63", v, 0);
    pix(2, 0, 0, v);
    chk("w1_px0_0", v, 1);
    pix(2, 127, 0, v);
    chk("w1_px127_0", v, 1);
    pix(2, 125, 0, v);
    chk("w1_px125_0", v, 0);
    count(2, cnt);
    chk("w1_count", cnt, 16);
    go(2, 2'd0, 12'h210, 8'hFE, 8'h3F, 4'd2);
    wdone(2, 1, c);
    chk("w2_cycles", c, 39);
    chk("w2_col", col2, 1);
    count(2, cnt);
    chk("w2_count", cnt, 0);
    // draw16 straddling the right edge
    ones = int'(fcnt);
    go(2, 2'd2, 12'h300, 8'd120, 8'd0, 4'd0);
    wdone(2, 1, c);
    chk("d16_cycles", c, 609);
    chk("d16_col", col2, 0);
    chk("d16_nfetch", 32'(fcnt - 8'(ones)), 32);
    for (int k = 0; k < 32; k++) chk($sformatf("d16_faddr%0d", k), flog[8'(ones + k)], 12'h300 + 12'(k));
    count(2, cnt);
    chk("d16_count", cnt, 256);
    pix(2, 120, 0, v);
    chk("d16_px120_0", v, 1);
    pix(2, 7, 15, v);
    chk("d16_px7_15", v, 1);
    pix(2, 8, 15, v);
    chk("d16_px8_15", v, 0);
    pix(2, 119, 3, v);
    chk("d16_px119_3", v, 0);
    pix(2, 0, 16, v);
    chk("d16_px0_16", v, 0);
    // asynchronous reset in the middle of a colliding draw
    go(1, 2'd0, 12'h200, 8'd5, 8'd5, 4'd1);
    wdone(1, 1, c);
    chk("r0_cycles", c, 12);
    go(1, 2'd0, 12'h200, 8'd5, 8'd5, 4'd1);
    repeat (5) @(negedge clk);
    chk("r_pre_col", col1, 1);
    chk("r_pre_busy", busy1, 1);
    #2 rst = 1;
    #1;
    chk("r_busy", busy1, 0);
    chk("r_done", done1, 0);
    chk("r_col", col1, 0);
    chk("r_mem_re", re1, 0);
    @(negedge clk);
    rst = 0;
    pix(1, 5, 5, v);
    chk("r_px_partial", v, 0);
    go(1, 2'd0, 12'h200, 8'd5, 8'd5, 4'd1);
    wdone(1, 1, c);
    chk("r_after_cycles", c, 12);
    chk("r_after_col", col1, 0);
    pix(1, 5, 5, v);
    chk("r_after_px", v, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
